// File: rtl/muldiv_seq.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle, start/busy/done handshake.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise div/divu are no-ops.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   step;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       msum;
  logic [WIDTH-1:0]     hi_fix, lo_fix;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 sa, sb;
  logic                 neg_q;
  logic                 done_nx;
  logic                 last;

`ifdef MULDIV_DIV_EN
  logic                 is_div, neg_r, div0;
  logic [WIDTH:0]       dtrial, ddiff;
  logic [WIDTH-1:0]     q, r;
`endif

  assign sa = op[0] & a[WIDTH-1];
  assign sb = op[0] & b[WIDTH-1];
  // W-bit negation read as unsigned gives the right magnitude even for MIN
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;

  assign last = (count == CW'(WIDTH - 1));
  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_nx = CALC;
`else
          if (op[1]) done_nx  = 1'b1;
          else       state_nx = CALC;
`endif
        end
      end
      CALC: begin
        if (flush)     state_nx = IDLE;
        else if (last) state_nx = FIX;
      end
      FIX: begin
        state_nx = IDLE;
        done_nx  = ~flush;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
         + (acc[0] ? {1'b0, opnd} : '0);
    step = {msum, acc[WIDTH-1:1]};
    prod = neg_q ? -acc : acc;
    hi_fix = prod[2*WIDTH-1:WIDTH];
    lo_fix = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    dtrial = acc[2*WIDTH-1:WIDTH-1];
    ddiff  = dtrial - {1'b0, opnd};
    q = acc[WIDTH-1:0];
    r = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      step = ddiff[WIDTH]
           ? {acc[2*WIDTH-2:0], 1'b0}
           : {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      // divide by zero falls out as rem=|a|, quotient forced to all ones
      lo_fix = div0 ? '1 : (neg_q ? -q : q);
      hi_fix = neg_r ? -r : r;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      opnd  <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
`endif
    end else begin
      done <= done_nx;
      unique case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            count <= '0;
            neg_q <= sa ^ sb;
`ifdef MULDIV_DIV_EN
            is_div <= op[1];
            neg_r  <= sa;
            div0   <= (b == '0);
            opnd   <= op[1] ? b_mag : a_mag;
            acc    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
`else
            opnd   <= a_mag;
            acc    <= {{WIDTH{1'b0}}, b_mag};
`endif
          end
        end
        CALC: begin
          acc   <= step;
          count <= count + CW'(1);
        end
        FIX: begin
          if (!flush) begin
            hi <= hi_fix;
            lo <= lo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
